aes256_key_expansion_iter: RTL and testbench
============================================

# aes256_key_expansion_iter

Iterative AES-256 key schedule. It loads a 256-bit cipher key and produces the 15 round keys (0..14) consumed through `i_round_key` by the round blocks of the unrolled cipher datapath. It computes one 128-bit round key per step using a single SubWord unit (4 S-boxes), then holds the full key bank stable for the cipher pipeline. It sits directly upstream of the round-block chain.

## Interface
- `NB_BYTE`, 8, bits per byte; only 8 is legal.
- `N_BYTES`, 16, bytes per round key; only 16 is legal.
- `N_KEY_BYTES`, 32, cipher key bytes; only 32 (AES-256) is legal.
- `N_ROUNDS`, 14, last round index; round keys 0..N_ROUNDS are generated.
- `i_clock`  in  1  clock; one clock domain, all state on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_key`  in  256  cipher key, FIPS-197 byte order: byte 0 at [255:248].
- `i_key_valid`  in  1  load request; sampled every cycle.
- `o_round_keys`  out  1920  round key k at [(k+1)*128-1 : k*128]; byte 0 of each key at its MSBs.
- `o_busy`  out  1  expansion in progress.
- `o_done`  out  1  all 15 round keys valid and stable.

## Operation
- FSM states:
  - IDLE: reset state, no keys valid.
  - EXPAND: generating keys 2..14.
  - DONE: bank stable.
- Load: `i_key_valid` high in any state (IDLE, EXPAND or DONE) captures `i_key`.
  - Key 0 is written with `i_key[255:128]`, key 1 with `i_key[127:0]`.
  - The key-index counter is set to 2, and the Rcon register to 0x01.
  - The next state is EXPAND, with `o_done`=0 and `o_busy`=1.
  - A load during EXPAND aborts the current expansion and restarts from the new key.
- Step for key k (k=2..14), where A = key k-2 and B = key k-1, both held in working registers:
  - temp = last word of B.
  - k even: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}. Rcon then doubles: 01,02,04,08,10,20,40.
  - k odd: temp = SubWord(temp), with no rotation and no Rcon.
  - w0 = A.w0^temp; w1 = A.w1^w0; w2 = A.w2^w1; w3 = A.w3^w2.
  - Key k is written to the bank. A becomes B, B becomes key k, and the counter increments.
- After key 14 is written: the next state is DONE, with `o_busy`=0 and `o_done`=1.
- DONE: the bank holds until the next load or reset. `i_key` changes without `i_key_valid` have no effect in any state.
- Bank slots k not yet written in the current expansion hold stale or zero data. Consumers use the bank only while `o_done`=1.
- The S-box is the same forward AES S-box used by the subbytes stage: GF(2^8) inverse plus affine transform, with input 0x00 giving output 0x63.

## Timing
- Reset (synchronous, highest priority over load):
  - All 1920 bits of `o_round_keys` = 0, `o_busy` = 0, `o_done` = 0.
  - FSM returns to IDLE, counter = 0, Rcon = 0x01.
  - Reset mid-EXPAND discards all progress.
- Without the macro, one key is produced per cycle:
  - Load sampled at edge E0: keys 0 and 1 visible after E0.
  - Key k written at edge E(k-1).
  - Key 14 and `o_done`=1 are both written at E13, giving a latency of 13 cycles from the load edge.
- `o_busy` is high from after E0 through E13 exclusive, i.e. 13 cycles; `o_done` rises in the same cycle `o_busy` falls.
- Back-to-back: a load in the first DONE cycle is accepted. `o_done` drops the following cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `AES_KEY_EXP_SBOX_REG_EN` defined:
  - A pipeline register follows the SubWord output. Each step takes 2 cycles: cycle 1 registers temp, cycle 2 does the XOR chain and the bank write.
  - Key k is written at edge E(2(k-1)); key 14 and `o_done` are written at E26.
  - `o_busy` is high for 26 cycles.
  - A load or reset during either phase behaves as specified above.
- Not defined: the single-cycle step, with 13-cycle latency.

## Test plan
- FIPS-197 A.3 key 603deb1015ca71be2b73aef0857d7781_1f352c073b6108d72d9810a30914dff4 -> key2 = 9ba354118e6925afa51a8b5f2067fcde; key14 = fe4890d1e6188d0b046df344706c631e; `o_done` rises exactly 13 cycles after the load edge (26 with the macro).
- Reset asserted for 1 cycle at expansion step 5 -> next cycle all outputs 0 and IDLE. A reload of the A.3 key then gives the same key14 with full latency.
- Load the all-zero key, then load A.3 at step 7 of the expansion -> restart; final bank matches A.3 only, with no residue from the zero key; latency counted from the second load.
- In DONE, toggle `i_key` randomly with `i_key_valid`=0 for 50 cycles -> `o_round_keys` and `o_done` unchanged.
- Back-to-back loads (A.3, then zero key on the first DONE cycle) -> `o_done` is 1 for exactly one cycle. Zero-key key2 = 62636363626363636263636362636363.
- `i_key_valid` held high continuously -> state stays EXPAND with counter at 2. `o_done` never rises until `i_key_valid` drops, then completes 13 cycles later.

Source files
------------

// File: rtl/aes256_key_expansion_iter.sv
// Iterative AES-256 key schedule: one 128-bit round key per step through a shared 4-S-box SubWord unit.
// Optional macro AES_KEY_EXP_SBOX_REG_EN inserts a register after SubWord, making each step two cycles.
module aes256_key_expansion_iter #(
  parameter int NB_BYTE     = 8,
  parameter int N_BYTES     = 16,
  parameter int N_KEY_BYTES = 32,
  parameter int N_ROUNDS    = 14
) (
  input  logic                                     i_clock,
  input  logic                                     i_reset,
  input  logic [NB_BYTE*N_KEY_BYTES-1:0]           i_key,
  input  logic                                     i_key_valid,
  output logic [NB_BYTE*N_BYTES*(N_ROUNDS+1)-1:0]  o_round_keys,
  output logic                                     o_busy,
  output logic                                     o_done
);

  localparam int         KEY_W    = NB_BYTE * N_BYTES;
  localparam logic [3:0] LAST_KEY = 4'(N_ROUNDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state_q;
  state_t             next_state;
  logic [KEY_W-1:0]   key_a_q;
  logic [KEY_W-1:0]   key_b_q;
  logic [3:0]         counter_q;
  logic [7:0]         rcon_q;
  logic               step_write;
  logic [31:0]        last_w;
  logic [31:0]        sub_in;
  logic [31:0]        sub_out;
  logic [31:0]        temp_calc;
  logic [31:0]        temp_use;
  logic [31:0]        w0;
  logic [31:0]        w1;
  logic [31:0]        w2;
  logic [31:0]        w3;
  logic [KEY_W-1:0]   new_key;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Field inverse as a^254 (square-and-multiply); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Even keys rotate and add Rcon; odd keys (AES-256 only) substitute the raw word.
  always_comb begin
    last_w    = key_b_q[31:0];
    sub_in    = counter_q[0] ? last_w : {last_w[23:0], last_w[31:24]};
    sub_out   = sub_word(sub_in);
    temp_calc = counter_q[0] ? sub_out : (sub_out ^ {rcon_q, 24'h000000});
  end

`ifdef AES_KEY_EXP_SBOX_REG_EN
  logic        phase_q;
  logic [31:0] temp_q;

  // Phase 0 captures the SubWord result; phase 1 performs the XOR chain and bank write.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      phase_q <= 1'b0;
      temp_q  <= 32'h0;
    end else if (i_key_valid) begin
      phase_q <= 1'b0;
    end else if (state_q == EXPAND) begin
      if (!phase_q) temp_q <= temp_calc;
      phase_q <= ~phase_q;
    end
  end

  assign step_write = phase_q;
  assign temp_use   = temp_q;
`else
  assign step_write = 1'b1;
  assign temp_use   = temp_calc;
`endif

  always_comb begin
    w0      = key_a_q[127:96] ^ temp_use;
    w1      = key_a_q[95:64]  ^ w0;
    w2      = key_a_q[63:32]  ^ w1;
    w3      = key_a_q[31:0]   ^ w2;
    new_key = {w0, w1, w2, w3};
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= next_state;
  end

  // A load wins in every state, which also makes it the abort path out of EXPAND.
  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    next_state = IDLE;
      EXPAND:  if (step_write && counter_q == LAST_KEY) next_state = DONE;
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
    if (i_key_valid) next_state = EXPAND;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_round_keys <= '0;
      key_a_q      <= '0;
      key_b_q      <= '0;
      counter_q    <= 4'd0;
      rcon_q       <= 8'h01;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_busy <= (next_state == EXPAND);
      o_done <= (next_state == DONE);
      if (i_key_valid) begin
        o_round_keys[KEY_W-1:0]       <= i_key[2*KEY_W-1:KEY_W];
        o_round_keys[2*KEY_W-1:KEY_W] <= i_key[KEY_W-1:0];
        key_a_q   <= i_key[2*KEY_W-1:KEY_W];
        key_b_q   <= i_key[KEY_W-1:0];
        counter_q <= 4'd2;
        rcon_q    <= 8'h01;
      end else if (state_q == EXPAND && step_write) begin
        o_round_keys[int'(counter_q)*KEY_W +: KEY_W] <= new_key;
        key_a_q   <= key_b_q;
        key_b_q   <= new_key;
        counter_q <= counter_q + 4'd1;
        if (!counter_q[0]) rcon_q <= {rcon_q[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_aes256_key_expansion_iter.sv
// Randomized self-checking bench for aes256_key_expansion_iter against a FIPS-197 word-array model.
// Honours AES_KEY_EXP_SBOX_REG_EN for the expected latency.
module tb_aes256_key_expansion_iter;

  localparam logic [255:0] KEY_A3   = 256'h603deb1015ca71be2b73aef0857d7781_1f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_ZERO = 256'h0;
`ifdef AES_KEY_EXP_SBOX_REG_EN
  localparam int LAT = 26;
`else
  localparam int LAT = 13;
`endif

  logic          i_clock;
  logic          i_reset;
  logic [255:0]  i_key;
  logic          i_key_valid;
  logic [1919:0] o_round_keys;
  logic          o_busy;
  logic          o_done;

  int vectors;
  int miscompares;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_keys [15];

  aes256_key_expansion_iter dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_key        (i_key),
    .i_key_valid  (i_key_valid),
    .o_round_keys (o_round_keys),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // The inverse is found by exhaustive search rather than exponentiation.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (ref_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] ref_sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic compute_model(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      temp = w[i-1];
      if (i % 8 == 0) begin
        temp = ref_sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc   = ref_mul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        temp = ref_sub_word(temp);
      end
      w[i] = w[i-8] ^ temp;
    end
    for (int k = 0; k < 15; k++) exp_keys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Called at a falling edge; the next rising edge samples the load.
  task automatic applyStimulus(input logic [255:0] key);
    i_key       = key;
    i_key_valid = 1'b1;
    @(negedge i_clock);
    i_key_valid = 1'b0;
  endtask

  task automatic check_bank(input string tag);
    for (int k = 0; k < 15; k++)
      checkOutput($sformatf("%s_key%0d", tag, k), o_round_keys[k*128 +: 128], exp_keys[k]);
  endtask

  task automatic check_zero(input string tag);
    checkOutput({tag, "_busy"}, 128'(o_busy), 128'd0);
    checkOutput({tag, "_done"}, 128'(o_done), 128'd0);
    for (int k = 0; k < 15; k++)
      checkOutput($sformatf("%s_key%0d", tag, k), o_round_keys[k*128 +: 128], 128'd0);
  endtask

  // Entered at the falling edge just after the load edge; returns in the first DONE cycle.
  task automatic wait_done(input string tag);
    int cycles;
    int busy_cnt;
    cycles   = 0;
    busy_cnt = int'(o_busy);
    while (!o_done && cycles < 100) begin
      @(negedge i_clock);
      cycles++;
      busy_cnt += int'(o_busy);
    end
    checkOutput({tag, "_latency"}, 128'(cycles), 128'(LAT));
    checkOutput({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(LAT));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_reset     = 1'b1;
    i_key       = '0;
    i_key_valid = 1'b0;
    build_sbox();

    repeat (2) @(negedge i_clock);
    check_zero("reset");
    i_reset = 1'b0;
    @(negedge i_clock);
    checkOutput("idle_busy", 128'(o_busy), 128'd0);
    checkOutput("idle_done", 128'(o_done), 128'd0);

    compute_model(KEY_A3);
    applyStimulus(KEY_A3);
    checkOutput("a3_load_busy", 128'(o_busy), 128'd1);
    checkOutput("a3_load_done", 128'(o_done), 128'd0);
    checkOutput("a3_load_key0", o_round_keys[127:0], exp_keys[0]);
    checkOutput("a3_load_key1", o_round_keys[255:128], exp_keys[1]);
    wait_done("a3");
    checkOutput("a3_key2_vec", o_round_keys[383:256], 128'h9ba354118e6925afa51a8b5f2067fcde);
    checkOutput("a3_key14_vec", o_round_keys[1919:1792], 128'hfe4890d1e6188d0b046df344706c631e);
    check_bank("a3");

    repeat (5) begin
      logic [255:0] rk;
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      compute_model(rk);
      @(negedge i_clock);
      applyStimulus(rk);
      wait_done("rand");
      check_bank("rand");
    end

    compute_model(KEY_A3);
    @(negedge i_clock);
    applyStimulus(KEY_A3);
    repeat (4) @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    check_zero("midreset");
    @(negedge i_clock);
    checkOutput("midreset_idle_busy", 128'(o_busy), 128'd0);
    applyStimulus(KEY_A3);
    wait_done("reload");
    checkOutput("reload_key14_vec", o_round_keys[1919:1792], 128'hfe4890d1e6188d0b046df344706c631e);
    check_bank("reload");

    @(negedge i_clock);
    applyStimulus(KEY_ZERO);
    repeat (6) @(negedge i_clock);
    applyStimulus(KEY_A3);
    wait_done("restart");
    check_bank("restart");

    repeat (50) begin
      i_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge i_clock);
      checkOutput("hold_done", 128'(o_done), 128'd1);
    end
    check_bank("hold");

    applyStimulus(KEY_A3);
    wait_done("b2b_first");
    checkOutput("b2b_done_high", 128'(o_done), 128'd1);
    applyStimulus(KEY_ZERO);
    checkOutput("b2b_done_drop", 128'(o_done), 128'd0);
    checkOutput("b2b_busy_rise", 128'(o_busy), 128'd1);
    compute_model(KEY_ZERO);
    wait_done("b2b_zero");
    checkOutput("zero_key2_vec", o_round_keys[383:256], 128'h62636363626363636263636362636363);
    check_bank("zero");

    i_key       = KEY_A3;
    i_key_valid = 1'b1;
    repeat (20) begin
      @(negedge i_clock);
      checkOutput("held_busy", 128'(o_busy), 128'd1);
      checkOutput("held_done", 128'(o_done), 128'd0);
    end
    checkOutput("held_slot2_stale", o_round_keys[383:256], exp_keys[2]);
    i_key_valid = 1'b0;
    compute_model(KEY_A3);
    wait_done("held");
    check_bank("held");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
